mem_stage: RTL and testbench

//   Pipeline MEM stage: consumes the EX_MEM bundle produced by the EX stage, resolves branches back to the IF stage
//   (BranchTaken/BranchTarget), performs data-memory loads/stores over a req/ack port, and drives the MEM_WB register.

---
 rtl/mem_stage_pkg.sv | 26 ++
 rtl/mem_stage_wb_reg.sv | 49 ++++
 rtl/mem_stage.sv | 166 ++++++++++++++++
 tb/tb_mem_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the MEM stage: widths, FSM encodings and the MEM_WB bundle.
package mem_stage_pkg;

    localparam int PC_W   = 8;
    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic [DATA_W-1:0] read_data;
        logic [DATA_W-1:0] alu_result;
        logic [REG_W-1:0]  write_reg;
    } mem_wb_t;

    // A bubble carries no control at all; it retires as an all-zero MEM_WB entry.
    function automatic logic is_bubble(input logic mem_read, input logic mem_write,
                                       input logic mem_to_reg, input logic reg_write,
                                       input logic branch);
        return !(mem_read | mem_write | mem_to_reg | reg_write | branch);
    endfunction

endpackage

// File: rtl/mem_stage_wb_reg.sv
// MEM_WB pipeline register: loads on load_en; squash kills the register write of the loaded entry.
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic              squash,
    input  logic              reg_write_in,
    input  logic              mem_to_reg_in,
    input  logic [DATA_W-1:0] read_data_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [REG_W-1:0]  write_reg_in,
    output logic              reg_write_out,
    output logic              mem_to_reg_out,
    output logic [DATA_W-1:0] read_data_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [REG_W-1:0]  write_reg_out
);

    mem_wb_t wb_q;
    mem_wb_t wb_d;

    always_comb begin
        wb_d = wb_q;
        if (load_en) begin
            wb_d.reg_write  = reg_write_in && !squash;
            wb_d.mem_to_reg = mem_to_reg_in;
            wb_d.read_data  = read_data_in;
            wb_d.alu_result = alu_result_in;
            wb_d.write_reg  = write_reg_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign reg_write_out  = wb_q.reg_write;
    assign mem_to_reg_out = wb_q.mem_to_reg;
    assign read_data_out  = wb_q.read_data;
    assign alu_result_out = wb_q.alu_result;
    assign write_reg_out  = wb_q.write_reg;

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: branch resolution, req/ack data-memory access with stall and timeout,
// and the MEM_WB register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EX_MEM_MemRead,
    input  logic              EX_MEM_MemWrite,
    input  logic              EX_MEM_MemtoReg,
    input  logic              EX_MEM_RegWrite,
    input  logic              EX_MEM_Branch,
    input  logic [DATA_W-1:0] EX_MEM_ALUResult,
    input  logic [PC_W-1:0]   EX_MEM_BranchTarget,
    input  logic [DATA_W-1:0] EX_MEM_WriteData,
    input  logic [REG_W-1:0]  EX_MEM_WriteReg,
    output logic              Stall,
    output logic              BranchTaken,
    output logic [PC_W-1:0]   BranchTarget,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              MEM_WB_RegWrite,
    output logic              MEM_WB_MemtoReg,
    output logic [DATA_W-1:0] MEM_WB_ReadData,
    output logic [DATA_W-1:0] MEM_WB_ALUResult,
    output logic [REG_W-1:0]  MEM_WB_WriteReg,
    output logic              MemError
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    logic [0:0]        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_error_q, mem_error_d;

    logic    mem_op;
    logic    stall;
    logic    wb_load;
    logic    wb_squash;
    mem_wb_t wb_in;

    assign mem_op = EX_MEM_MemRead | EX_MEM_MemWrite;

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        mem_error_d = mem_error_q;
        stall       = 1'b0;
        wb_load     = 1'b0;
        wb_squash   = 1'b0;
        wb_in       = '0;

        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    // The counter starts at 1 so it equals the number of BUSY cycles seen so far.
                    stall   = 1'b1;
                    state_d = ST_BUSY;
                    req_d   = 1'b1;
                    we_d    = EX_MEM_MemWrite;
                    addr_d  = EX_MEM_ALUResult[ADDR_W-1:0];
                    wdata_d = EX_MEM_WriteData;
                    cnt_d   = CNT_W'(1);
                end else begin
                    wb_load = 1'b1;
                    if (!is_bubble(EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemtoReg,
                                   EX_MEM_RegWrite, EX_MEM_Branch)) begin
                        wb_in.reg_write  = EX_MEM_RegWrite;
                        wb_in.mem_to_reg = EX_MEM_MemtoReg;
                        wb_in.alu_result = EX_MEM_ALUResult;
                        wb_in.write_reg  = EX_MEM_WriteReg;
                    end
                end
            end
            ST_BUSY: begin
                if (dmem_ack || cnt_q == CNT_MAX) begin
                    // EX_MEM is held by the stall, so its fields still describe this access.
                    wb_load          = 1'b1;
                    wb_squash        = !dmem_ack;
                    wb_in.reg_write  = EX_MEM_RegWrite;
                    wb_in.mem_to_reg = EX_MEM_MemtoReg;
                    wb_in.read_data  = (dmem_ack && !we_q) ? dmem_rdata : '0;
                    wb_in.alu_result = EX_MEM_ALUResult;
                    wb_in.write_reg  = EX_MEM_WriteReg;
                    mem_error_d      = mem_error_q | !dmem_ack;
                    state_d          = ST_IDLE;
                    req_d            = 1'b0;
                    cnt_d            = '0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            mem_error_q <= mem_error_d;
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk            (clk),
        .rst            (rst),
        .load_en        (wb_load),
        .squash         (wb_squash),
        .reg_write_in   (wb_in.reg_write),
        .mem_to_reg_in  (wb_in.mem_to_reg),
        .read_data_in   (wb_in.read_data),
        .alu_result_in  (wb_in.alu_result),
        .write_reg_in   (wb_in.write_reg),
        .reg_write_out  (MEM_WB_RegWrite),
        .mem_to_reg_out (MEM_WB_MemtoReg),
        .read_data_out  (MEM_WB_ReadData),
        .alu_result_out (MEM_WB_ALUResult),
        .write_reg_out  (MEM_WB_WriteReg)
    );

    // A branch paired with a memory op resolves only once the access stops stalling.
    assign BranchTaken  = EX_MEM_Branch && (EX_MEM_ALUResult == '0) && !stall;
    assign BranchTarget = BranchTaken ? EX_MEM_BranchTarget : '0;

    assign Stall      = stall;
    assign dmem_req   = req_q;
    assign dmem_we    = req_q & we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign MemError   = mem_error_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus random ops against a transaction-level model.
module tb_mem_stage;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemtoReg, EX_MEM_RegWrite, EX_MEM_Branch;
    logic [31:0] EX_MEM_ALUResult, EX_MEM_WriteData;
    logic [7:0]  EX_MEM_BranchTarget;
    logic [4:0]  EX_MEM_WriteReg;
    logic        Stall, BranchTaken;
    logic [7:0]  BranchTarget;
    logic        dmem_req, dmem_we;
    logic [7:0]  dmem_addr;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        MEM_WB_RegWrite, MEM_WB_MemtoReg;
    logic [31:0] MEM_WB_ReadData, MEM_WB_ALUResult;
    logic [4:0]  MEM_WB_WriteReg;
    logic        MemError;

    mem_stage #(.ADDR_W(8), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
        .EX_MEM_MemtoReg(EX_MEM_MemtoReg), .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .EX_MEM_Branch(EX_MEM_Branch), .EX_MEM_ALUResult(EX_MEM_ALUResult),
        .EX_MEM_BranchTarget(EX_MEM_BranchTarget), .EX_MEM_WriteData(EX_MEM_WriteData),
        .EX_MEM_WriteReg(EX_MEM_WriteReg),
        .Stall(Stall), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_MemtoReg(MEM_WB_MemtoReg),
        .MEM_WB_ReadData(MEM_WB_ReadData), .MEM_WB_ALUResult(MEM_WB_ALUResult),
        .MEM_WB_WriteReg(MEM_WB_WriteReg), .MemError(MemError)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Expected observable state, updated by the transaction model.
    logic        exp_stall, exp_req, exp_bt, exp_memerr, exp_partial, exp_we;
    logic [7:0]  exp_target, exp_addr;
    logic [31:0] exp_wdata;
    logic        e_rw, e_m2r;
    logic [31:0] e_rd, e_alu;
    logic [4:0]  e_wreg;
    int          stall_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic check_cycle(input string tag);
        if (Stall === 1'b1) stall_seen++;
        chk({tag, ".Stall"},        32'(Stall),        32'(exp_stall));
        chk({tag, ".dmem_req"},     32'(dmem_req),     32'(exp_req));
        chk({tag, ".BranchTaken"},  32'(BranchTaken),  32'(exp_bt));
        chk({tag, ".BranchTarget"}, 32'(BranchTarget), exp_bt ? 32'(exp_target) : 32'h0);
        chk({tag, ".MemError"},     32'(MemError),     32'(exp_memerr));
        if (exp_req) begin
            chk({tag, ".dmem_addr"},  32'(dmem_addr), 32'(exp_addr));
            chk({tag, ".dmem_we"},    32'(dmem_we),   32'(exp_we));
            chk({tag, ".dmem_wdata"}, dmem_wdata,     exp_wdata);
        end
        chk({tag, ".WB_RegWrite"}, 32'(MEM_WB_RegWrite), 32'(e_rw));
        if (!exp_partial) begin
            chk({tag, ".WB_MemtoReg"},  32'(MEM_WB_MemtoReg), 32'(e_m2r));
            chk({tag, ".WB_ReadData"},  MEM_WB_ReadData,      e_rd);
            chk({tag, ".WB_ALUResult"}, MEM_WB_ALUResult,     e_alu);
            chk({tag, ".WB_WriteReg"},  32'(MEM_WB_WriteReg), 32'(e_wreg));
        end
    endtask

    task automatic set_ctrl(input int kind);
        EX_MEM_MemRead  = (kind == 2) || (kind == 5) || (kind == 6);
        EX_MEM_MemWrite = (kind == 3) || (kind == 5);
        EX_MEM_MemtoReg = (kind == 2) || (kind == 5) || (kind == 6);
        EX_MEM_RegWrite = (kind == 1) || (kind == 2) || (kind == 5) || (kind == 6);
        EX_MEM_Branch   = (kind == 4) || (kind == 6);
    endtask

    // Architectural effect of an instruction leaving MEM.
    task automatic retire(input int kind, input logic [31:0] rd);
        exp_partial = 1'b0;
        if (kind == 0) begin
            e_rw = 0; e_m2r = 0; e_rd = 0; e_alu = 0; e_wreg = 0;
        end else begin
            e_rw   = EX_MEM_RegWrite;
            e_m2r  = EX_MEM_MemtoReg;
            e_rd   = rd;
            e_alu  = EX_MEM_ALUResult;
            e_wreg = EX_MEM_WriteReg;
        end
    endtask

    // Kinds: 0 bubble, 1 alu, 2 load, 3 store, 4 branch, 5 load+store, 6 load+branch.
    // ack_k = BUSY cycle carrying the ack (1-based); 0 means the memory never answers.
    task automatic run_op(input int kind, input logic [31:0] alu, input logic [31:0] wdat,
                          input logic [4:0] wreg, input logic [7:0] tgt,
                          input logic [31:0] rdata, input int ack_k);
        logic mem_op, br_cond;
        int   exp_cycles;
        set_ctrl(kind);
        EX_MEM_ALUResult    = alu;
        EX_MEM_WriteData    = wdat;
        EX_MEM_WriteReg     = wreg;
        EX_MEM_BranchTarget = tgt;
        dmem_ack            = 1'b0;
        dmem_rdata          = $urandom;
        mem_op     = EX_MEM_MemRead | EX_MEM_MemWrite;
        br_cond    = EX_MEM_Branch && (alu == 32'h0);
        exp_target = tgt;
        stall_seen = 0;
        if (!mem_op) begin
            dmem_ack = 1'($urandom_range(0, 1));
            #1;
            exp_stall = 0; exp_req = 0; exp_bt = br_cond;
            check_cycle("pass");
            @(negedge clk);
            dmem_ack = 1'b0;
            retire(kind, 32'h0);
            exp_cycles = 0;
        end else begin
            #1;
            exp_stall = 1; exp_req = 0; exp_bt = 0;
            check_cycle("issue");
            exp_addr  = alu[7:0];
            exp_we    = EX_MEM_MemWrite;
            exp_wdata = wdat;
            for (int k = 1; k <= TO; k++) begin
                @(negedge clk);
                exp_req = 1;
                if (k == ack_k) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdata;
                    #1;
                    exp_stall = 0; exp_bt = br_cond;
                    check_cycle("ack");
                    @(negedge clk);
                    dmem_ack   = 1'b0;
                    dmem_rdata = $urandom;
                    exp_req    = 0;
                    retire(kind, (EX_MEM_MemRead && !EX_MEM_MemWrite) ? rdata : 32'h0);
                    break;
                end
                #1;
                exp_stall = (k != TO);
                exp_bt    = (k == TO) && br_cond;
                check_cycle("busy");
                if (k == TO) begin
                    @(negedge clk);
                    exp_req     = 0;
                    exp_memerr  = 1;
                    e_rw        = 0;
                    exp_partial = 1;
                end
            end
            // Stall covers the issue cycle plus every BUSY cycle before the deciding one.
            exp_cycles = (ack_k >= 1 && ack_k <= TO) ? ack_k : TO;
        end
        chk("stall_cycles", 32'(stall_seen), 32'(exp_cycles));
        $display("txn kind=%0d alu=0x%08h ack_k=%0d stall_cycles=%0d", kind, alu, ack_k, stall_seen);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r_alu;
        int          r_kind, r_ack;

        rst = 1'b1;
        set_ctrl(0);
        EX_MEM_ALUResult = 0; EX_MEM_WriteData = 0; EX_MEM_WriteReg = 0; EX_MEM_BranchTarget = 0;
        dmem_ack = 0; dmem_rdata = 0;
        exp_stall = 0; exp_req = 0; exp_bt = 0; exp_memerr = 0; exp_partial = 0; exp_we = 0;
        exp_target = 0; exp_addr = 0; exp_wdata = 0;
        e_rw = 0; e_m2r = 0; e_rd = 0; e_alu = 0; e_wreg = 0;
        stall_seen = 0;

        // Reset held two cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_cycle("reset");
        chk("reset.dmem_addr",  32'(dmem_addr),  32'h0);
        chk("reset.dmem_we",    32'(dmem_we),    32'h0);
        chk("reset.dmem_wdata", dmem_wdata,      32'h0);
        @(negedge clk);

        // Load answered in the 4th BUSY cycle; store answered in the 1st.
        run_op(2, 32'h10, 32'h0, 5'd5, 8'h0, 32'hDEADBEEF, 4);
        run_op(3, 32'h04, 32'h12345678, 5'd9, 8'h0, 32'h0, 1);

        // Branch resolution, taken and not taken.
        run_op(4, 32'h0, 32'h0, 5'd0, 8'd16, 32'h0, 0);
        run_op(4, 32'h1, 32'h0, 5'd0, 8'd16, 32'h0, 0);

        // Hung load times out, then an ALU op flows with single-cycle latency.
        run_op(2, 32'h44, 32'h0, 5'd7, 8'h0, 32'h0, 0);
        run_op(1, 32'h0000BEEF, 32'h0, 5'd3, 8'h0, 32'h0, 0);

        // Random mix of all instruction kinds.
        for (int i = 0; i < 40; i++) begin
            r_kind = $urandom_range(0, 6);
            r_alu  = $urandom;
            if ((r_kind == 4 || r_kind == 6) && $urandom_range(0, 1) == 1) r_alu = 32'h0;
            r_ack = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 5);
            run_op(r_kind, r_alu, $urandom, 5'($urandom), 8'($urandom), $urandom, r_ack);
        end

        // Reset in the 2nd BUSY cycle abandons the access; the late ack is ignored.
        set_ctrl(2);
        EX_MEM_ALUResult = 32'h20;
        EX_MEM_WriteReg  = 5'd11;
        dmem_ack = 1'b0;
        #1;
        exp_stall = 1; exp_req = 0; exp_bt = 0;
        check_cycle("rst_issue");
        exp_addr = 8'h20; exp_we = 0; exp_wdata = EX_MEM_WriteData;
        @(negedge clk);
        #1;
        exp_req = 1;
        check_cycle("rst_busy1");
        @(negedge clk);
        set_ctrl(0);
        rst = 1'b1;
        #1;
        exp_stall = 0; exp_req = 0; exp_bt = 0; exp_memerr = 0; exp_partial = 0;
        e_rw = 0; e_m2r = 0; e_rd = 0; e_alu = 0; e_wreg = 0;
        check_cycle("rst_mid");
        @(negedge clk);
        rst        = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        EX_MEM_ALUResult = 32'h0;
        #1;
        check_cycle("rst_late_ack");
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
        check_cycle("rst_after");
        @(negedge clk);

        // A few ops after reset, ending with a bubble so the last retirement is observed.
        run_op(2, 32'h33, 32'h0, 5'd2, 8'h0, 32'h0BADF00D, 2);
        run_op(6, 32'h0, 32'h0, 5'd4, 8'd99, 32'h55AA55AA, 3);
        run_op(5, 32'h7F, 32'hA5A5A5A5, 5'd6, 8'h0, 32'hFFFF0000, 2);
        run_op(0, 32'h0, 32'h0, 5'd0, 8'h0, 32'h0, 0);
        run_op(0, 32'h0, 32'h0, 5'd0, 8'h0, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
